// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares the register file's single write port
// between the ALU writeback (A) and the load/immediate path (B).
module reg_write_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [2:0]        addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [2:0]        addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  output logic [7:0]        wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_src,
  output logic [7:0]        collide_cnt
);

  logic              elig_a;
  logic              elig_b;
  logic              win_a;
  logic              win_b;
  logic              collide;
  logic [2:0]        win_addr;
  logic [DATA_W-1:0] win_data;

  // A source granted this cycle sits out, so a held request is never granted twice.
  always_comb begin
    elig_a   = req_a & ~gnt_a;
    elig_b   = req_b & ~gnt_b;
    win_a    = elig_a & (~elig_b | last_src);
    win_b    = elig_b & (~elig_a | ~last_src);
    collide  = elig_a & elig_b & (addr_a == addr_b);
    win_addr = win_b ? addr_b : addr_a;
    win_data = win_b ? data_b : data_a;
  end

  // Register 0 maps to the MSB of wr_en, hence the right shift from bit 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      wr_en       <= 8'h00;
      wr_data     <= '0;
      last_src    <= 1'b1;
      collide_cnt <= 8'h00;
    end else begin
      gnt_a <= win_a;
      gnt_b <= win_b;
      if (win_a | win_b) begin
        wr_en    <= 8'b1000_0000 >> win_addr;
        wr_data  <= win_data;
        last_src <= win_b;
      end else begin
        wr_en <= 8'h00;
      end
      if (collide && (collide_cnt != 8'hFF)) begin
        collide_cnt <= collide_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: expected grants go into a scoreboard
// queue and a negedge monitor pops one per observed grant.
module tb_reg_write_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a;
  logic [2:0] addr_a;
  logic [7:0] data_a;
  logic       gnt_a;
  logic       req_b;
  logic [2:0] addr_b;
  logic [7:0] data_b;
  logic       gnt_b;
  logic [7:0] wr_en;
  logic [7:0] wr_data;
  logic       last_src;
  logic [7:0] collide_cnt;

  typedef struct packed {
    logic       src;
    logic [7:0] wr_en;
    logic [7:0] data;
  } grant_t;

  grant_t expected_q[$];
  int     errors = 0;
  int     checks = 0;

  reg_write_arbiter #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a       (req_a),
    .addr_a      (addr_a),
    .data_a      (data_a),
    .gnt_a       (gnt_a),
    .req_b       (req_b),
    .addr_b      (addr_b),
    .data_b      (data_b),
    .gnt_b       (gnt_b),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .last_src    (last_src),
    .collide_cnt (collide_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that consumed them.
  task automatic applyStimulus(input logic r, input logic ra, input logic [2:0] aa,
                               input logic [7:0] da, input logic rb,
                               input logic [2:0] ab, input logic [7:0] db);
    rst    = r;
    req_a  = ra;
    addr_a = aa;
    data_a = da;
    req_b  = rb;
    addr_b = ab;
    data_b = db;
    @(posedge clk);
    #1;
  endtask

  task automatic expectGrant(input logic src, input logic [7:0] en, input logic [7:0] data);
    grant_t g;
    g.src   = src;
    g.wr_en = en;
    g.data  = data;
    expected_q.push_back(g);
  endtask

  // Monitor: every grant seen on the port must match the head of the scoreboard.
  always @(negedge clk) begin
    if (gnt_a === 1'b1 || gnt_b === 1'b1) begin
      if (expected_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_grant: got gnt_a=%b gnt_b=%b expected none at %0t",
                 gnt_a, gnt_b, $time);
      end else begin
        grant_t g;
        g = expected_q.pop_front();
        checkOutput("grant_src_a", {31'd0, gnt_a}, {31'd0, ~g.src});
        checkOutput("grant_src_b", {31'd0, gnt_b}, {31'd0, g.src});
        checkOutput("grant_wr_en", {24'd0, wr_en}, {24'd0, g.wr_en});
        checkOutput("grant_wr_data", {24'd0, wr_data}, {24'd0, g.data});
        checkOutput("grant_last_src", {31'd0, last_src}, {31'd0, g.src});
      end
    end
  end

  initial begin
    rst = 1'b1; req_a = 1'b0; addr_a = '0; data_a = '0;
    req_b = 1'b0; addr_b = '0; data_b = '0;

    // Reset with both sources requesting: nothing may be granted.
    applyStimulus(1, 1, 3'd1, 8'h11, 1, 3'd6, 8'h66);
    applyStimulus(1, 1, 3'd1, 8'h11, 1, 3'd6, 8'h66);
    checkOutput("reset_gnt_a", {31'd0, gnt_a}, 32'd0);
    checkOutput("reset_gnt_b", {31'd0, gnt_b}, 32'd0);
    checkOutput("reset_wr_en", {24'd0, wr_en}, 32'd0);
    checkOutput("reset_wr_data", {24'd0, wr_data}, 32'd0);
    checkOutput("reset_last_src", {31'd0, last_src}, 32'd1);
    checkOutput("reset_collide_cnt", {24'd0, collide_cnt}, 32'd0);

    // Round-robin: continuous requests alternate A,B,... starting with A.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) expectGrant(1'b0, 8'b0100_0000, 8'h11);
      else            expectGrant(1'b1, 8'b0000_0010, 8'h66);
      applyStimulus(0, 1, 3'd1, 8'h11, 1, 3'd6, 8'h66);
    end
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    checkOutput("rr_idle_wr_en", {24'd0, wr_en}, 32'd0);
    checkOutput("rr_idle_wr_data_hold", {24'd0, wr_data}, 32'h66);
    checkOutput("rr_idle_last_src_hold", {31'd0, last_src}, 32'd1);
    checkOutput("rr_collide_cnt", {24'd0, collide_cnt}, 32'd0);

    // Single source A: one grant, then the requester drops.
    expectGrant(1'b0, 8'b0001_0000, 8'h5A);
    applyStimulus(0, 1, 3'd3, 8'h5A, 0, 3'd0, 8'h00);
    applyStimulus(0, 0, 3'd3, 8'h5A, 0, 3'd0, 8'h00);
    checkOutput("single_no_regrant", {31'd0, gnt_a}, 32'd0);
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    checkOutput("single_last_src", {31'd0, last_src}, 32'd0);
    checkOutput("single_wr_data", {24'd0, wr_data}, 32'h5A);

    // Lone requester B held high: grant every other cycle with empty gaps.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) expectGrant(1'b1, 8'b0010_0000, 8'h22);
      applyStimulus(0, 0, 3'd0, 8'h00, 1, 3'd2, 8'h22);
      checkOutput("bubble_gnt_b", {31'd0, gnt_b}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 1) checkOutput("bubble_gap_wr_en", {24'd0, wr_en}, 32'd0);
    end
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);

    // Collision on register 5 from reset: A first, then B.
    applyStimulus(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    expectGrant(1'b0, 8'b0000_0100, 8'hAA);
    applyStimulus(0, 1, 3'd5, 8'hAA, 1, 3'd5, 8'hBB);
    expectGrant(1'b1, 8'b0000_0100, 8'hBB);
    applyStimulus(0, 0, 3'd5, 8'hAA, 1, 3'd5, 8'hBB);
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    checkOutput("collide_first_cnt", {24'd0, collide_cnt}, 32'd1);
    checkOutput("collide_final_data", {24'd0, wr_data}, 32'hBB);

    // Repeat collisions up to 300 total; the counter must stick at FF.
    for (int k = 2; k <= 300; k++) begin
      expectGrant(1'b0, 8'b0000_0100, 8'hAA);
      applyStimulus(0, 1, 3'd5, 8'hAA, 1, 3'd5, 8'hBB);
      expectGrant(1'b1, 8'b0000_0100, 8'hBB);
      applyStimulus(0, 0, 3'd5, 8'hAA, 1, 3'd5, 8'hBB);
      applyStimulus(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      if (k == 100) checkOutput("collide_cnt_100", {24'd0, collide_cnt}, 32'd100);
      if (k == 254) checkOutput("collide_cnt_254", {24'd0, collide_cnt}, 32'd254);
      if (k == 255) checkOutput("collide_cnt_255", {24'd0, collide_cnt}, 32'hFF);
    end
    checkOutput("collide_cnt_saturated", {24'd0, collide_cnt}, 32'hFF);

    // Mid-stream reset lands on the edge where B would have been granted.
    expectGrant(1'b0, 8'b0100_0000, 8'h11);
    applyStimulus(0, 1, 3'd1, 8'h11, 1, 3'd6, 8'h66);
    applyStimulus(1, 1, 3'd1, 8'h11, 1, 3'd6, 8'h66);
    checkOutput("midrst_gnt_a", {31'd0, gnt_a}, 32'd0);
    checkOutput("midrst_gnt_b", {31'd0, gnt_b}, 32'd0);
    checkOutput("midrst_wr_en", {24'd0, wr_en}, 32'd0);
    checkOutput("midrst_last_src", {31'd0, last_src}, 32'd1);
    checkOutput("midrst_collide_cnt", {24'd0, collide_cnt}, 32'd0);
    expectGrant(1'b0, 8'b0100_0000, 8'h11);
    applyStimulus(0, 1, 3'd1, 8'h11, 1, 3'd6, 8'h66);
    expectGrant(1'b1, 8'b0000_0010, 8'h66);
    applyStimulus(0, 1, 3'd1, 8'h11, 1, 3'd6, 8'h66);
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);

    checkOutput("scoreboard_drained", expected_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
